// File: rtl/handshake_fifo_pkg.sv
// Shared sizing helpers and occupancy-state encoding for handshake_elastic_fifo.
// Optional feature macro used by the top: HANDSHAKE_FIFO_BYPASS_EN.
package handshake_fifo_pkg;

    localparam int unsigned MIN_SLOTS = 1;
    localparam int unsigned MAX_SLOTS = 256;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } fifo_state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned slots);
        return (clog2(slots) < 1) ? 1 : clog2(slots);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned slots);
        return clog2(slots + 1);
    endfunction

endpackage

// File: rtl/handshake_fifo_ptr.sv
// Modulo-NUM_SLOTS pointer with enable and synchronous active-high reset.
module handshake_fifo_ptr #(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned WIDTH     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] ptr
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(NUM_SLOTS - 1);

    // Explicit wrap so non-power-of-two depths never index past the last slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            if (ptr == LAST) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/handshake_elastic_fifo.sv
// Opaque elastic FIFO on a valid/ready channel; ins_ready depends on registered state only.
// Define HANDSHAKE_FIFO_BYPASS_EN for same-cycle pass-through while empty.
module handshake_elastic_fifo
    import handshake_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_SLOTS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int unsigned PTR_W = ptr_width(NUM_SLOTS);
    localparam int unsigned CNT_W = cnt_width(NUM_SLOTS);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_FULL = CNT_W'(NUM_SLOTS);

    logic [DATA_WIDTH-1:0] mem [NUM_SLOTS];
    ptr_t                  rd_ptr;
    ptr_t                  wr_ptr;
    cnt_t                  count;
    fifo_state_e           state;
    logic                  fifo_valid;
    logic                  push;
    logic                  store;
    logic                  deq;

    always_comb begin
        state = ST_PARTIAL;
        if (count == '0) begin
            state = ST_EMPTY;
        end else if (count == CNT_FULL) begin
            state = ST_FULL;
        end
    end

    assign ins_ready  = !rst && (state != ST_FULL);
    assign fifo_valid = (state != ST_EMPTY);
    assign push       = ins_valid && ins_ready;
    assign deq        = fifo_valid && outs_ready;

`ifdef HANDSHAKE_FIFO_BYPASS_EN
    logic bypass;
    logic pass;

    // While empty the stage is transparent; a token taken downstream the same cycle is never stored.
    assign bypass     = (state == ST_EMPTY) && !rst;
    assign pass       = bypass && ins_valid && outs_ready;
    assign outs_valid = bypass ? ins_valid : fifo_valid;
    assign outs       = bypass ? ins : mem[rd_ptr];
    assign store      = push && !pass;
`else
    assign outs_valid = fifo_valid;
    assign outs       = mem[rd_ptr];
    assign store      = push;
`endif

    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr] <= ins;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({store, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    handshake_fifo_ptr #(
        .NUM_SLOTS(NUM_SLOTS),
        .WIDTH    (PTR_W)
    ) u_wr_ptr (
        .clk(clk),
        .rst(rst),
        .en (store),
        .ptr(wr_ptr)
    );

    handshake_fifo_ptr #(
        .NUM_SLOTS(NUM_SLOTS),
        .WIDTH    (PTR_W)
    ) u_rd_ptr (
        .clk(clk),
        .rst(rst),
        .en (deq),
        .ptr(rd_ptr)
    );

endmodule

// File: tb/tb_handshake_elastic_fifo.sv
// Directed bench: a 4-slot instance for main scenarios and a 3-slot instance for wrap-around.
module tb_handshake_elastic_fifo;

`ifdef HANDSHAKE_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] ins4, outs4;
    logic        ins_valid4, ins_ready4, outs_valid4, outs_ready4;
    logic [31:0] ins3, outs3;
    logic        ins_valid3, ins_ready3, outs_valid3, outs_ready3;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    handshake_elastic_fifo #(.DATA_WIDTH(32), .NUM_SLOTS(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .ins(ins4), .ins_valid(ins_valid4), .ins_ready(ins_ready4),
        .outs(outs4), .outs_valid(outs_valid4), .outs_ready(outs_ready4)
    );

    handshake_elastic_fifo #(.DATA_WIDTH(32), .NUM_SLOTS(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .ins(ins3), .ins_valid(ins_valid3), .ins_ready(ins_ready3),
        .outs(outs3), .outs_valid(outs_valid3), .outs_ready(outs_ready3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ins4 = 32'h1E; ins_valid4 = 1'b1; outs_ready4 = 1'b0;
        ins3 = 32'h0;  ins_valid3 = 1'b0; outs_ready3 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (ins_ready4 !== 1'b0) begin
                errors++; $display("FAIL reset_ins_ready: got %b expected 0", ins_ready4);
            end
            checks++;
            if (outs_valid4 !== 1'b0) begin
                errors++; $display("FAIL reset_outs_valid: got %b expected 0", outs_valid4);
            end
        end
        tick();
        rst = 1'b0; ins_valid4 = 1'b0;
        #1;
        checks++;
        if (ins_ready4 !== 1'b1) begin
            errors++; $display("FAIL post_reset_ins_ready: got %b expected 1", ins_ready4);
        end
        checks++;
        if (outs_valid4 !== 1'b0) begin
            errors++; $display("FAIL post_reset_outs_valid: got %b expected 0", outs_valid4);
        end
        checks++;
        if (ins_ready3 !== 1'b1 || outs_valid3 !== 1'b0) begin
            errors++; $display("FAIL post_reset_dut3: got ready=%b valid=%b expected ready=1 valid=0", ins_ready3, outs_valid3);
        end
        tick();
    endtask

    task automatic test_single();
        ins4 = 32'h1E; ins_valid4 = 1'b1; outs_ready4 = 1'b1;
        #1;
        checks++;
        if (ins_ready4 !== 1'b1 || outs_valid4 !== 1'b0) begin
            errors++; $display("FAIL single_cycle_n: got ready=%b valid=%b expected ready=1 valid=0", ins_ready4, outs_valid4);
        end
        tick();
        ins_valid4 = 1'b0;
        #1;
        checks++;
        if (outs_valid4 !== 1'b1 || outs4 !== 32'h1E) begin
            errors++; $display("FAIL single_cycle_n1: got valid=%b data=%h expected valid=1 data=1e", outs_valid4, outs4);
        end
        tick();
        checks++;
        if (outs_valid4 !== 1'b0) begin
            errors++; $display("FAIL single_cycle_n2: got valid=%b expected 0", outs_valid4);
        end
    endtask

    task automatic test_bypass();
        ins4 = 32'h1E; ins_valid4 = 1'b1; outs_ready4 = 1'b1;
        #1;
        checks++;
        if (outs_valid4 !== 1'b1 || outs4 !== 32'h1E || ins_ready4 !== 1'b1) begin
            errors++; $display("FAIL bypass_pass: got valid=%b data=%h ready=%b expected 1/1e/1", outs_valid4, outs4, ins_ready4);
        end
        tick();
        ins_valid4 = 1'b0;
        #1;
        checks++;
        if (outs_valid4 !== 1'b0) begin
            errors++; $display("FAIL bypass_not_stored: got valid=%b expected 0", outs_valid4);
        end
        ins4 = 32'h2F; ins_valid4 = 1'b1; outs_ready4 = 1'b0;
        #1;
        checks++;
        if (outs_valid4 !== 1'b1 || outs4 !== 32'h2F) begin
            errors++; $display("FAIL bypass_stall_view: got valid=%b data=%h expected 1/2f", outs_valid4, outs4);
        end
        tick();
        ins_valid4 = 1'b0; ins4 = 32'h0;
        #1;
        checks++;
        if (outs_valid4 !== 1'b1 || outs4 !== 32'h2F) begin
            errors++; $display("FAIL bypass_stored: got valid=%b data=%h expected 1/2f", outs_valid4, outs4);
        end
        outs_ready4 = 1'b1;
        tick();
        checks++;
        if (outs_valid4 !== 1'b0) begin
            errors++; $display("FAIL bypass_drain: got valid=%b expected 0", outs_valid4);
        end
    endtask

    task automatic test_fill();
        logic [31:0] exp_q [5];
        int unsigned got;
        logic        accepted;
        exp_q = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        outs_ready4 = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            ins4 = 32'(i); ins_valid4 = 1'b1;
            #1;
            checks++;
            if (ins_ready4 !== 1'b1) begin
                errors++; $display("FAIL fill_ready_%0d: got %b expected 1", i, ins_ready4);
            end
            tick();
        end
        ins4 = 32'h5; ins_valid4 = 1'b1;
        #1;
        checks++;
        if (ins_ready4 !== 1'b0 || outs_valid4 !== 1'b1 || outs4 !== 32'h1) begin
            errors++; $display("FAIL fill_full: got ready=%b valid=%b data=%h expected 0/1/1", ins_ready4, outs_valid4, outs4);
        end
        outs_ready4 = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            #1;
            if (outs_valid4) begin
                checks++;
                if (outs4 !== exp_q[got]) begin
                    errors++; $display("FAIL fill_order_%0d: got %h expected %h", got, outs4, exp_q[got]);
                end
                got++;
            end
            accepted = ins_valid4 && ins_ready4;
            tick();
            if (accepted) ins_valid4 = 1'b0;
        end
        checks++;
        if (got != 5) begin
            errors++; $display("FAIL fill_drain_count: got %0d tokens expected 5", got);
        end
        #1;
        checks++;
        if (outs_valid4 !== 1'b0) begin
            errors++; $display("FAIL fill_no_dup: got valid=%b expected 0", outs_valid4);
        end
    endtask

    task automatic test_full_pop();
        outs_ready4 = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            ins4 = 32'h11 + 32'(i); ins_valid4 = 1'b1;
            tick();
        end
        ins4 = 32'h15; ins_valid4 = 1'b1; outs_ready4 = 1'b1;
        #1;
        checks++;
        if (ins_ready4 !== 1'b0 || outs4 !== 32'h11) begin
            errors++; $display("FAIL full_pop_only: got ready=%b data=%h expected 0/11", ins_ready4, outs4);
        end
        tick();
        outs_ready4 = 1'b0;
        #1;
        checks++;
        if (ins_ready4 !== 1'b1 || outs4 !== 32'h12) begin
            errors++; $display("FAIL full_pop_next: got ready=%b data=%h expected 1/12", ins_ready4, outs4);
        end
        tick();
        ins_valid4 = 1'b0;
        #1;
        checks++;
        if (ins_ready4 !== 1'b0) begin
            errors++; $display("FAIL full_pop_refill: got ready=%b expected 0", ins_ready4);
        end
        outs_ready4 = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (outs_valid4 !== 1'b1 || outs4 !== 32'h12 + 32'(i)) begin
                errors++; $display("FAIL full_pop_drain_%0d: got valid=%b data=%h expected 1/%h", i, outs_valid4, outs4, 32'h12 + 32'(i));
            end
            tick();
        end
        checks++;
        if (outs_valid4 !== 1'b0) begin
            errors++; $display("FAIL full_pop_empty: got valid=%b expected 0", outs_valid4);
        end
    endtask

    task automatic test_wrap();
        int unsigned sent, got, occ;
        logic        rdy, exp_v, push, pop;
        sent = 0; got = 0; occ = 0; rdy = 1'b1;
        for (int c = 0; c < 80 && got < 10; c++) begin
            ins3 = 32'(sent); ins_valid3 = (sent < 10); outs_ready3 = rdy;
            #1;
            exp_v = (occ != 0) || (BYP && ins_valid3);
            checks++;
            if (outs_valid3 !== exp_v) begin
                errors++; $display("FAIL wrap_valid_c%0d: got %b expected %b", c, outs_valid3, exp_v);
            end
            checks++;
            if (ins_ready3 !== (occ < 3)) begin
                errors++; $display("FAIL wrap_ready_c%0d: got %b expected %b (occupancy %0d)", c, ins_ready3, occ < 3, occ);
            end
            push = ins_valid3 && ins_ready3;
            pop  = outs_valid3 && outs_ready3;
            if (pop) begin
                checks++;
                if (outs3 !== 32'(got)) begin
                    errors++; $display("FAIL wrap_order_%0d: got %h expected %h", got, outs3, 32'(got));
                end
                got++;
            end
            if (push) sent++;
            if (push && !pop) occ++;
            else if (!push && pop) occ--;
            rdy = !rdy;
            tick();
        end
        ins_valid3 = 1'b0; outs_ready3 = 1'b0;
        checks++;
        if (got != 10) begin
            errors++; $display("FAIL wrap_count: got %0d tokens expected 10", got);
        end
    endtask

    task automatic test_reset_mid();
        outs_ready4 = 1'b0;
        ins4 = 32'h31; ins_valid4 = 1'b1;
        tick();
        ins4 = 32'h32;
        tick();
        ins_valid4 = 1'b0;
        #1;
        checks++;
        if (outs_valid4 !== 1'b1 || outs4 !== 32'h31) begin
            errors++; $display("FAIL mid_prefill: got valid=%b data=%h expected 1/31", outs_valid4, outs4);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (outs_valid4 !== 1'b0 || ins_ready4 !== 1'b1) begin
            errors++; $display("FAIL mid_after_reset: got valid=%b ready=%b expected 0/1", outs_valid4, ins_ready4);
        end
        ins4 = 32'hAA; ins_valid4 = 1'b1;
        tick();
        ins_valid4 = 1'b0;
        #1;
        checks++;
        if (outs_valid4 !== 1'b1 || outs4 !== 32'hAA) begin
            errors++; $display("FAIL mid_first_out: got valid=%b data=%h expected 1/aa", outs_valid4, outs4);
        end
        outs_ready4 = 1'b1;
        tick();
        checks++;
        if (outs_valid4 !== 1'b0) begin
            errors++; $display("FAIL mid_drained: got valid=%b expected 0", outs_valid4);
        end
        outs_ready4 = 1'b0;
    endtask

    initial begin
        test_reset();
`ifdef HANDSHAKE_FIFO_BYPASS_EN
        test_bypass();
`else
        test_single();
`endif
        test_fill();
        test_full_pop();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
